// File: rtl/regfile_2r1w.sv
// regfile_2r1w: DEPTH x WIDTH flop-based register file with two registered
// read ports and one write port. Optional hardwired zero register and
// optional same-edge write-to-read forwarding.
//
// Read handshake: a read request is ren_x=1 with raddr_x at a rising edge.
// There is no ready; every request is served. rvalid_x is high for exactly
// the cycle after each requesting edge. rdata_x is meaningful while rvalid_x
// is high and holds its last value otherwise.
module regfile_2r1w #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             ren_a,
    input  logic [AW-1:0]    raddr_a,
    output logic [WIDTH-1:0] rdata_a,
    output logic             rvalid_a,
    input  logic             ren_b,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_b,
    output logic             rvalid_b
);

    // DEPTH in address width plus one bit, so DEPTH=2**AW still compares correctly.
    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             wr_ok;

    // Index 0 is port A, index 1 is port B.
    logic [1:0]            ren;
    logic [1:0][AW-1:0]    raddr;
    logic [1:0][WIDTH-1:0] rdata_q;
    logic [1:0][WIDTH-1:0] rdata_d;
    logic [1:0]            rvalid_q;
    logic [1:0]            rvalid_d;

    assign ren   = {ren_b, ren_a};
    assign raddr = {raddr_b, raddr_a};

    assign rdata_a  = rdata_q[0];
    assign rdata_b  = rdata_q[1];
    assign rvalid_a = rvalid_q[0];
    assign rvalid_b = rvalid_q[1];

    // A write lands only for an in-range address that is not the hardwired zero register.
    always_comb begin
        wr_ok = we && ({1'b0, waddr} < DEPTH_W) && !((ZERO_REG != 0) && (waddr == '0));
    end

    // Next storage contents: unchanged except the accepted write target.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (wr_ok) begin
            mem_d[waddr] = wdata;
        end
    end

    // Read-port next state: out-of-range and zero register read 0, forwarding beats storage.
    always_comb begin
        rdata_d  = rdata_q;
        rvalid_d = ren;
        for (int p = 0; p < 2; p++) begin
            if (ren[p]) begin
                if ({1'b0, raddr[p]} >= DEPTH_W) begin
                    rdata_d[p] = '0;
                end else if ((ZERO_REG != 0) && (raddr[p] == '0)) begin
                    rdata_d[p] = '0;
                end else if ((BYPASS != 0) && wr_ok && (waddr == raddr[p])) begin
                    rdata_d[p] = wdata;
                end else begin
                    rdata_d[p] = mem_q[raddr[p]];
                end
            end
        end
    end

    // State update; asynchronous reset clears every entry and both read ports.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rdata_q  <= '0;
            rvalid_q <= '0;
        end else begin
            mem_q    <= mem_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

endmodule

// File: tb/tb_regfile_2r1w.sv
// tb_regfile_2r1w: directed bench for regfile_2r1w. Two instances share the
// inputs: u_dut uses the defaults (DEPTH=32, ZERO_REG=1, BYPASS=1) and u_alt
// uses DEPTH=24, ZERO_REG=0, BYPASS=0, so one stimulus covers both variants.
module tb_regfile_2r1w;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        ren_a, ren_b;
  logic [4:0]  raddr_a, raddr_b;
  logic [31:0] rdata_a, rdata_b, alt_rdata_a, alt_rdata_b;
  logic        rvalid_a, rvalid_b, alt_rvalid_a, alt_rvalid_b;

  regfile_2r1w u_dut (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .ren_a(ren_a), .raddr_a(raddr_a), .rdata_a(rdata_a), .rvalid_a(rvalid_a),
    .ren_b(ren_b), .raddr_b(raddr_b), .rdata_b(rdata_b), .rvalid_b(rvalid_b)
  );

  regfile_2r1w #(.WIDTH(32), .DEPTH(24), .ZERO_REG(0), .BYPASS(0)) u_alt (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .ren_a(ren_a), .raddr_a(raddr_a), .rdata_a(alt_rdata_a), .rvalid_a(alt_rvalid_a),
    .ren_b(ren_b), .raddr_b(raddr_b), .rdata_b(alt_rdata_b), .rvalid_b(alt_rvalid_b)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model [32];
  logic [31:0] alt_model [24];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                       input logic ra, input logic [4:0] aa,
                       input logic rb, input logic [4:0] ab);
    we = w; waddr = wa; wdata = wd;
    ren_a = ra; raddr_a = aa; ren_b = rb; raddr_b = ab;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Read every address on both ports (B walks backwards) and expect zeros.
  task automatic read_all_zero(input string tag);
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 5'd0, 32'd0, 1'b1, 5'(i), 1'b1, 5'(31 - i));
      step();
      check($sformatf("%s_vld_a[%0d]", tag, i), {31'd0, rvalid_a}, 32'd1);
      check($sformatf("%s_vld_b[%0d]", tag, i), {31'd0, rvalid_b}, 32'd1);
      check($sformatf("%s_rd_a[%0d]", tag, i), rdata_a, 32'd0);
      check($sformatf("%s_rd_b[%0d]", tag, i), rdata_b, 32'd0);
      check($sformatf("%s_alt_rd_a[%0d]", tag, i), alt_rdata_a, 32'd0);
      check($sformatf("%s_alt_rd_b[%0d]", tag, i), alt_rdata_b, 32'd0);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        ren;
    logic [4:0]  raddr;
    logic        exp_v;
    logic        chk_d;
    logic [31:0] exp_d;
    logic [31:0] alt_d;
  } vec_t;

  vec_t vecs[11];

  initial begin
    // Reset with random inputs: everything must read back 0.
    drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
          1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
          1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
    repeat (3) step();
    check("rst_vld_a", {31'd0, rvalid_a}, 32'd0);
    check("rst_vld_b", {31'd0, rvalid_b}, 32'd0);
    check("rst_rd_a", rdata_a, 32'd0);
    check("rst_rd_b", rdata_b, 32'd0);
    check("rst_alt_vld_a", {31'd0, alt_rvalid_a}, 32'd0);
    rst_n = 1'b1;
    read_all_zero("post_rst");

    // Write sweep: reg i = A5A5_0000 + i for i = 1..31.
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
    for (int i = 0; i < 24; i++) alt_model[i] = 32'd0;
    for (int i = 1; i < 32; i++) begin
      drive(1'b1, 5'(i), 32'hA5A5_0000 + 32'(i), 1'b0, 5'd0, 1'b0, 5'd0);
      model[i] = 32'hA5A5_0000 + 32'(i);
      if (i < 24) alt_model[i] = 32'hA5A5_0000 + 32'(i);
      step();
    end
    check("wr_idle_vld_a", {31'd0, rvalid_a}, 32'd0);

    // Parallel read sweep on both ports, back-to-back.
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 5'd0, 32'd0, 1'b1, 5'(i), 1'b1, 5'(i));
      exp_q.push_back(model[i]);
      step();
      check($sformatf("sweep_vld_a[%0d]", i), {31'd0, rvalid_a}, 32'd1);
      check($sformatf("sweep_vld_b[%0d]", i), {31'd0, rvalid_b}, 32'd1);
      check($sformatf("sweep_rd_a[%0d]", i), rdata_a, exp_q.pop_front());
      check($sformatf("sweep_rd_b[%0d]", i), rdata_b, model[i]);
      check($sformatf("sweep_alt_rd_a[%0d]", i), alt_rdata_a, (i < 24) ? alt_model[i] : 32'd0);
    end
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0);
    step();
    check("hold_vld_a", {31'd0, rvalid_a}, 32'd0);
    check("hold_vld_b", {31'd0, rvalid_b}, 32'd0);
    check("hold_rd_a", rdata_a, 32'hA5A5_001F);
    check("hold_alt_rd_a", alt_rdata_a, 32'd0);

    // Bypass, zero register, out-of-range and hold corner cases, one edge each.
    vecs[0]  = '{1'b1, 5'd5,  32'h1111_1111, 1'b0, 5'd0,  1'b0, 1'b0, 32'h0,          32'h0};
    vecs[1]  = '{1'b1, 5'd5,  32'h2222_2222, 1'b1, 5'd5,  1'b1, 1'b1, 32'h2222_2222, 32'h1111_1111};
    vecs[2]  = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd5,  1'b1, 1'b1, 32'h2222_2222, 32'h2222_2222};
    vecs[3]  = '{1'b1, 5'd0,  32'hFFFF_FFFF, 1'b1, 5'd0,  1'b1, 1'b1, 32'h0,          32'h0};
    vecs[4]  = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd0,  1'b1, 1'b1, 32'h0,          32'hFFFF_FFFF};
    vecs[5]  = '{1'b1, 5'd30, 32'hDEAD_BEEF, 1'b1, 5'd30, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'h0};
    vecs[6]  = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd30, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'h0};
    vecs[7]  = '{1'b1, 5'd23, 32'h0BAD_F00D, 1'b1, 5'd23, 1'b1, 1'b1, 32'h0BAD_F00D, 32'hA5A5_0017};
    vecs[8]  = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd23, 1'b1, 1'b1, 32'h0BAD_F00D, 32'h0BAD_F00D};
    vecs[9]  = '{1'b1, 5'd7,  32'h7777_7777, 1'b1, 5'd6,  1'b1, 1'b1, 32'hA5A5_0006, 32'hA5A5_0006};
    vecs[10] = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  1'b0, 1'b1, 32'hA5A5_0006, 32'hA5A5_0006};
    for (int v = 0; v < 11; v++) begin
      drive(vecs[v].we, vecs[v].waddr, vecs[v].wdata, vecs[v].ren, vecs[v].raddr,
            vecs[v].ren, vecs[v].raddr);
      step();
      check($sformatf("vec%0d_vld_a", v), {31'd0, rvalid_a}, {31'd0, vecs[v].exp_v});
      check($sformatf("vec%0d_vld_b", v), {31'd0, rvalid_b}, {31'd0, vecs[v].exp_v});
      check($sformatf("vec%0d_alt_vld_a", v), {31'd0, alt_rvalid_a}, {31'd0, vecs[v].exp_v});
      if (vecs[v].chk_d) begin
        check($sformatf("vec%0d_rd_a", v), rdata_a, vecs[v].exp_d);
        check($sformatf("vec%0d_rd_b", v), rdata_b, vecs[v].exp_d);
        check($sformatf("vec%0d_alt_rd_a", v), alt_rdata_a, vecs[v].alt_d);
        check($sformatf("vec%0d_alt_rd_b", v), alt_rdata_b, vecs[v].alt_d);
      end
    end

    // Reset asserted between edges while both ports read every cycle.
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 1'b1, 5'd23);
    step();
    step();
    check("mid_pre_rd_a", rdata_a, 32'h2222_2222);
    check("mid_pre_rd_b", rdata_b, 32'h0BAD_F00D);
    check("mid_pre_alt_rd_b", alt_rdata_b, 32'h0BAD_F00D);
    #3;
    rst_n = 1'b0;
    we = 1'b1; waddr = 5'd9; wdata = $urandom;
    #1;
    check("mid_async_vld_a", {31'd0, rvalid_a}, 32'd0);
    check("mid_async_rd_a", rdata_a, 32'd0);
    check("mid_async_vld_b", {31'd0, rvalid_b}, 32'd0);
    check("mid_async_rd_b", rdata_b, 32'd0);
    check("mid_async_alt_rd_a", alt_rdata_a, 32'd0);
    repeat (2) step();
    check("mid_held_vld_a", {31'd0, rvalid_a}, 32'd0);
    #3;
    rst_n = 1'b1;
    read_all_zero("mid_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
